// File: rtl/nano_pkg.sv
// rtl/nano_pkg.sv - shared widths and state type for the nano memory responder
package nano_pkg;

  localparam int NANO_I_W_C       = 8;
  localparam int NANO_I_ADR_W_C   = 10;
  localparam int NANO_D_W_C       = 4;
  localparam int NANO_D_ADR_W_C   = 4;
  localparam int NANO_FUNC_OUTS_C = 2;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_BOOT,
    ST_RUN
  } nano_mem_state_t;

endpackage

// File: rtl/nano_sp_ram.sv
// rtl/nano_sp_ram.sv - single-port synchronous RAM, read-before-write, no reset
module nano_sp_ram #(
  parameter int W  = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Write and registered read share one address; a read in the write cycle sees the old word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/nano_mem_responder.sv
// rtl/nano_mem_responder.sv - IMEM/DMEM server with DMEM clear, IMEM boot load and FUNC registers
module nano_mem_responder
  import nano_pkg::*;
#(
  parameter int I_W       = NANO_I_W_C,
  parameter int I_ADR_W   = NANO_I_ADR_W_C,
  parameter int D_W       = NANO_D_W_C,
  parameter int D_ADR_W   = NANO_D_ADR_W_C,
  parameter int FUNC_OUTS = NANO_FUNC_OUTS_C
) (
  input  logic                     i_nano_clk,
  input  logic                     i_nano_rst_n,
  input  logic                     i_boot_valid,
  input  logic [I_W-1:0]           i_boot_data,
  input  logic                     i_boot_last,
  output logic                     o_boot_ready,
  output logic                     o_boot_done,
  input  logic [I_ADR_W-1:0]       i_instr_addr,
  input  logic                     i_instr_oe,
  output logic [I_W-1:0]           o_instr_data,
  input  logic [D_ADR_W-1:0]       i_dmem_addr,
  input  logic                     i_dmem_oe,
  input  logic                     i_dmem_we,
  input  logic [D_W-1:0]           i_dmem_wdata,
  output logic [D_W-1:0]           o_dmem_rdata,
  output logic [FUNC_OUTS*D_W-1:0] o_func
);

  localparam logic [D_ADR_W-1:0] CLR_MAX  = '1;
  localparam logic [I_ADR_W-1:0] BOOT_MAX = '1;

  nano_mem_state_t state, state_nxt;

  logic [D_ADR_W-1:0] clr_ptr;
  logic [I_ADR_W-1:0] bptr;
  logic               boot_acc;
  logic               run;

  logic               imem_we, imem_re;
  logic [I_ADR_W-1:0] imem_addr;
  logic [I_W-1:0]     imem_q;
  logic               dmem_we, dmem_re;
  logic [D_ADR_W-1:0] dmem_addr;
  logic [D_W-1:0]     dmem_wdata;
  logic [D_W-1:0]     dmem_q;

  // RAM read registers have no reset, so outputs are masked until a real RUN read lands
  logic instr_vld, dmem_vld;
  logic [D_W-1:0] func_q [FUNC_OUTS];

  assign run          = (state == ST_RUN);
  assign boot_acc     = (state == ST_BOOT) && i_boot_valid;
  assign o_boot_ready = (state == ST_BOOT);
  assign o_boot_done  = run;
  assign o_instr_data = instr_vld ? imem_q : '0;
  assign o_dmem_rdata = dmem_vld ? dmem_q : '0;

  // State register
  always_ff @(posedge i_nano_clk) begin
    if (!i_nano_rst_n) state <= ST_CLEAR;
    else               state <= state_nxt;
  end

  // Next state: CLEAR sweeps all of DMEM, BOOT ends on last word or the top IMEM slot
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_ptr == CLR_MAX) state_nxt = ST_BOOT;
      ST_BOOT:  if (boot_acc && (i_boot_last || bptr == BOOT_MAX)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Clear and boot pointers; bptr restarts at 0 for every boot and never wraps
  always_ff @(posedge i_nano_clk) begin
    if (!i_nano_rst_n) begin
      clr_ptr <= '0;
      bptr    <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        bptr    <= '0;
      end
      if (boot_acc && bptr != BOOT_MAX) bptr <= bptr + 1'b1;
    end
  end

  // RAM port muxing by state; requests outside RUN never reach the arrays
  always_comb begin
    imem_we    = 1'b0;
    imem_re    = 1'b0;
    imem_addr  = i_instr_addr;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    dmem_addr  = i_dmem_addr;
    dmem_wdata = i_dmem_wdata;
    case (state)
      ST_CLEAR: begin
        dmem_we    = 1'b1;
        dmem_addr  = clr_ptr;
        dmem_wdata = '0;
      end
      ST_BOOT: begin
        imem_we   = i_boot_valid;
        imem_addr = bptr;
      end
      ST_RUN: begin
        imem_re = i_instr_oe;
        dmem_we = i_dmem_we;
        dmem_re = i_dmem_oe;
      end
      default: ;
    endcase
  end

  // Read-data valid flags: set by the first RUN read, dropped by reset
  always_ff @(posedge i_nano_clk) begin
    if (!i_nano_rst_n) begin
      instr_vld <= 1'b0;
      dmem_vld  <= 1'b0;
    end else begin
      if (imem_re) instr_vld <= 1'b1;
      if (dmem_re) dmem_vld  <= 1'b1;
    end
  end

  // FUNC shadow flops track writes to the topmost DMEM words
  always_ff @(posedge i_nano_clk) begin
    if (!i_nano_rst_n || state == ST_CLEAR) begin
      for (int j = 0; j < FUNC_OUTS; j++) func_q[j] <= '0;
    end else if (run && i_dmem_we) begin
      for (int j = 0; j < FUNC_OUTS; j++)
        if (i_dmem_addr == D_ADR_W'((2**D_ADR_W) - 1 - j)) func_q[j] <= i_dmem_wdata;
    end
  end

  // Slice 0 (top DMEM word) occupies the most-significant nibble of o_func
  for (genvar j = 0; j < FUNC_OUTS; j++) begin : g_func
    assign o_func[(FUNC_OUTS-1-j)*D_W +: D_W] = func_q[j];
  end

  nano_sp_ram #(.W(I_W), .AW(I_ADR_W)) u_imem (
    .clk   (i_nano_clk),
    .we    (imem_we),
    .re    (imem_re),
    .addr  (imem_addr),
    .wdata (i_boot_data),
    .rdata (imem_q)
  );

  nano_sp_ram #(.W(D_W), .AW(D_ADR_W)) u_dmem (
    .clk   (i_nano_clk),
    .we    (dmem_we),
    .re    (dmem_re),
    .addr  (dmem_addr),
    .wdata (dmem_wdata),
    .rdata (dmem_q)
  );

endmodule

// File: tb/tb_nano_mem_responder.sv
// tb/tb_nano_mem_responder.sv - directed self-checking bench for nano_mem_responder
module tb_nano_mem_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot_valid = 1'b0;
  logic [7:0] boot_data = '0;
  logic       boot_last = 1'b0;
  logic       boot_ready;
  logic       boot_done;
  logic [9:0] instr_addr = '0;
  logic       instr_oe = 1'b0;
  logic [7:0] instr_data;
  logic [3:0] dmem_addr = '0;
  logic       dmem_oe = 1'b0;
  logic       dmem_we = 1'b0;
  logic [3:0] dmem_wdata = '0;
  logic [3:0] dmem_rdata;
  logic [7:0] func;

  int n_asrt = 0;
  int n_fail = 0;

  nano_mem_responder dut (
    .i_nano_clk   (clk),
    .i_nano_rst_n (rst_n),
    .i_boot_valid (boot_valid),
    .i_boot_data  (boot_data),
    .i_boot_last  (boot_last),
    .o_boot_ready (boot_ready),
    .o_boot_done  (boot_done),
    .i_instr_addr (instr_addr),
    .i_instr_oe   (instr_oe),
    .o_instr_data (instr_data),
    .i_dmem_addr  (dmem_addr),
    .i_dmem_oe    (dmem_oe),
    .i_dmem_we    (dmem_we),
    .i_dmem_wdata (dmem_wdata),
    .o_dmem_rdata (dmem_rdata),
    .o_func       (func)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    boot_valid = 1'b0;
    boot_last  = 1'b0;
    instr_oe   = 1'b0;
    dmem_oe    = 1'b0;
    dmem_we    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 16'(boot_ready), 16'h0);
    chk({tag, "_done"},  16'(boot_done),  16'h0);
    chk({tag, "_instr"}, 16'(instr_data), 16'h0);
    chk({tag, "_rdata"}, 16'(dmem_rdata), 16'h0);
    chk({tag, "_func"},  16'(func),       16'h0);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("clear_ready", 16'(boot_ready), 16'h0);
    end
    tick();
    chk("boot_ready_up", 16'(boot_ready), 16'h1);
  endtask

  task automatic boot_word(input logic [7:0] d, input logic last);
    boot_valid = 1'b1;
    boot_data  = d;
    boot_last  = last;
    tick();
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a);
    instr_addr = a;
    instr_oe   = 1'b1;
    tick();
    instr_oe = 1'b0;
  endtask

  task automatic dwrite(input logic [3:0] a, input logic [3:0] d);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_we    = 1'b1;
    tick();
    dmem_we = 1'b0;
  endtask

  task automatic dread(input logic [3:0] a);
    dmem_addr = a;
    dmem_oe   = 1'b1;
    tick();
    dmem_oe = 1'b0;
  endtask

  initial begin
    // Reset, then DMEM clear; a fetch strobe during CLEAR must be ignored
    do_reset();
    chk_outputs_zero("reset");
    instr_oe = 1'b1;
    tick();
    instr_oe = 1'b0;
    chk("clear_fetch_ignored", 16'(instr_data), 16'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("clear_ready_15", 16'(boot_ready), 16'h0);
    tick();
    chk("boot_ready_16", 16'(boot_ready), 16'h1);
    chk("boot_done_low", 16'(boot_done), 16'h0);

    // Three-word boot with valid gaps
    boot_word(8'h11, 1'b0);
    tick();
    boot_word(8'h22, 1'b0);
    tick();
    chk("boot_2_done", 16'(boot_done), 16'h0);
    chk("boot_2_ready", 16'(boot_ready), 16'h1);
    boot_word(8'h33, 1'b1);
    chk("boot_3_done", 16'(boot_done), 16'h1);
    chk("boot_3_ready", 16'(boot_ready), 16'h0);
    boot_word(8'hEE, 1'b1);
    chk("extra_boot_ready", 16'(boot_ready), 16'h0);

    // Fetch with 1-cycle latency and hold
    fetch(10'd2);
    chk("fetch_2", 16'(instr_data), 16'h33);
    tick();
    chk("fetch_hold", 16'(instr_data), 16'h33);
    fetch(10'd0);
    chk("fetch_0", 16'(instr_data), 16'h11);
    fetch(10'd1);
    chk("fetch_1", 16'(instr_data), 16'h22);

    // DMEM write/read and read-before-write
    dread(4'd3);
    chk("dmem_cleared", 16'(dmem_rdata), 16'h0);
    dwrite(4'd3, 4'hA);
    dread(4'd3);
    chk("dmem_rd_A", 16'(dmem_rdata), 16'hA);
    dmem_oe = 1'b1;
    dwrite(4'd3, 4'h5);
    dmem_oe = 1'b0;
    chk("dmem_rbw_old", 16'(dmem_rdata), 16'hA);
    tick();
    chk("dmem_rd_hold", 16'(dmem_rdata), 16'hA);
    dread(4'd3);
    chk("dmem_rd_5", 16'(dmem_rdata), 16'h5);

    // FUNC registers mirror DMEM[15] (upper nibble) and DMEM[14]
    dwrite(4'd15, 4'h7);
    chk("func_first", 16'(func), 16'h70);
    dwrite(4'd14, 4'h9);
    chk("func_both", 16'(func), 16'h79);
    dread(4'd15);
    chk("dmem_rd_15", 16'(dmem_rdata), 16'h7);

    // Reset mid-RUN, then abort a boot after five words with a reset
    do_reset();
    chk_outputs_zero("reset_run");
    wait_clear();
    chk("func_after_clear", 16'(func), 16'h0);
    boot_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      boot_data = 8'hA0 + 8'(i);
      tick();
    end
    boot_valid = 1'b0;
    chk("midboot_done", 16'(boot_done), 16'h0);
    do_reset();
    chk_outputs_zero("reset_boot");
    wait_clear();
    boot_word(8'h5C, 1'b1);
    chk("reboot_done", 16'(boot_done), 16'h1);
    fetch(10'd0);
    chk("reboot_imem0", 16'(instr_data), 16'h5C);
    fetch(10'd4);
    chk("reboot_imem4", 16'(instr_data), 16'hA4);
    dread(4'd3);
    chk("reboot_dmem_cleared", 16'(dmem_rdata), 16'h0);

    // Full-depth boot without last: leaves BOOT after word 1023, 1025th never accepted
    do_reset();
    wait_clear();
    boot_valid = 1'b1;
    for (int i = 0; i < 1023; i++) begin
      boot_data = 8'(i);
      tick();
    end
    chk("full_1023_done", 16'(boot_done), 16'h0);
    chk("full_1023_ready", 16'(boot_ready), 16'h1);
    boot_data = 8'(1023);
    tick();
    chk("full_1024_done", 16'(boot_done), 16'h1);
    chk("full_1024_ready", 16'(boot_ready), 16'h0);
    boot_data = 8'h77;
    tick();
    chk("full_1025_ready", 16'(boot_ready), 16'h0);
    boot_valid = 1'b0;
    fetch(10'd1023);
    chk("full_imem1023", 16'(instr_data), 16'hFF);
    fetch(10'd0);
    chk("full_imem0", 16'(instr_data), 16'h00);
    fetch(10'd1000);
    chk("full_imem1000", 16'(instr_data), 16'hE8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
